// File: rtl/gpo_access_arbiter.sv
// gpo_access_arbiter: round-robin arbiter/sequencer for two hosts onto the GPO bank port (optional GPO_ARB_WPROT_EN)
module gpo_access_arbiter #(
  parameter logic [15:0] PROT_MASK = 16'h0000
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        REQ1,
  input  logic        RD_WR1,
  input  logic [3:0]  ADDR1,
  input  logic [7:0]  WDATA1,
  output logic        ACK1,
  output logic [7:0]  RDATA1,
  output logic        ERR1,
  input  logic        REQ2,
  input  logic        RD_WR2,
  input  logic [3:0]  ADDR2,
  input  logic [7:0]  WDATA2,
  output logic        ACK2,
  output logic [7:0]  RDATA2,
  output logic        ERR2,
  output logic        PORT_CS,
  output logic [15:0] OFFSET_SEL,
  output logic        RD_WR,
  output logic [7:0]  DIN,
  input  logic [7:0]  DOUT
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, rd_q, rd_d, prot_q, prot_d;
  logic cs_q, cs_d, ack1_q, ack1_d, ack2_q, ack2_d, err2_q, err2_d;
  logic [15:0] offset_q, offset_d;
  logic [7:0] din_q, din_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic pick2, sel_rd, blk;
  logic [3:0] sel_addr;
  assign pick2 = REQ2 & (~REQ1 | ~last_q);
  assign sel_rd = pick2 ? RD_WR2 : RD_WR1;
  assign sel_addr = pick2 ? ADDR2 : ADDR1;
`ifdef GPO_ARB_WPROT_EN
  assign blk = pick2 & ~RD_WR2 & PROT_MASK[ADDR2];
`else
  logic unused_prot;
  assign unused_prot = ^PROT_MASK;
  assign blk = 1'b0;
`endif
  assign ACK1 = ack1_q;
  assign ACK2 = ack2_q;
  assign ERR1 = 1'b0;
  assign ERR2 = err2_q;
  assign RDATA1 = rdata1_q;
  assign RDATA2 = rdata2_q;
  assign PORT_CS = cs_q;
  assign OFFSET_SEL = offset_q;
  assign RD_WR = rd_q;
  assign DIN = din_q;
  // next-state and registered-output decode; bank/ack outputs are pulses computed one state ahead
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    rd_d = rd_q;
    prot_d = prot_q;
    din_d = din_q;
    cs_d = 1'b0;
    offset_d = '0;
    ack1_d = 1'b0;
    ack2_d = 1'b0;
    err2_d = 1'b0;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    case (state_q)
      IDLE: if (REQ1 | REQ2) begin
        gnt_d = pick2;
        last_d = pick2;
        rd_d = sel_rd;
        din_d = pick2 ? WDATA2 : WDATA1;
        prot_d = blk;
        cs_d = ~blk;
        offset_d = blk ? '0 : 16'd1 << sel_addr;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = rd_q ? CAPTURE : DONE;
        ack1_d = ~rd_q & ~gnt_q;
        ack2_d = ~rd_q & gnt_q;
        err2_d = ~rd_q & gnt_q & prot_q;
      end
      CAPTURE: begin
        state_d = DONE;
        ack1_d = ~gnt_q;
        ack2_d = gnt_q;
        rdata1_d = gnt_q ? rdata1_q : DOUT;
        rdata2_d = gnt_q ? DOUT : rdata2_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset clears every output and favours requester 1 on the first tie
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
      rd_q <= 1'b0;
      prot_q <= 1'b0;
      din_q <= '0;
      cs_q <= 1'b0;
      offset_q <= '0;
      ack1_q <= 1'b0;
      ack2_q <= 1'b0;
      err2_q <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      rd_q <= rd_d;
      prot_q <= prot_d;
      din_q <= din_d;
      cs_q <= cs_d;
      offset_q <= offset_d;
      ack1_q <= ack1_d;
      ack2_q <= ack2_d;
      err2_q <= err2_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end
endmodule

// File: tb/tb_gpo_access_arbiter.sv
// tb_gpo_access_arbiter: directed self-checking bench for gpo_access_arbiter
module tb_gpo_access_arbiter;
`ifdef GPO_ARB_WPROT_EN
  localparam logic [15:0] PM = 16'h0001;
  localparam logic WP = 1'b1;
`else
  localparam logic [15:0] PM = 16'h0000;
  localparam logic WP = 1'b0;
`endif
  logic SYSCLK = 1'b0, RESET_N = 1'b0;
  logic REQ1 = 0, RD_WR1 = 0, REQ2 = 0, RD_WR2 = 0;
  logic [3:0] ADDR1 = 0, ADDR2 = 0;
  logic [7:0] WDATA1 = 0, WDATA2 = 0, DOUT = 0, bank_rd = 0;
  logic ACK1, ERR1, ACK2, ERR2, PORT_CS, RD_WR;
  logic [7:0] RDATA1, RDATA2, DIN;
  logic [15:0] OFFSET_SEL;
  int checks = 0, failures = 0, cs_cnt = 0, ack_cnt = 0;
  int order[$];

  gpo_access_arbiter #(.PROT_MASK(PM)) dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .REQ1(REQ1), .RD_WR1(RD_WR1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .ACK1(ACK1), .RDATA1(RDATA1), .ERR1(ERR1),
    .REQ2(REQ2), .RD_WR2(RD_WR2), .ADDR2(ADDR2), .WDATA2(WDATA2),
    .ACK2(ACK2), .RDATA2(RDATA2), .ERR2(ERR2),
    .PORT_CS(PORT_CS), .OFFSET_SEL(OFFSET_SEL), .RD_WR(RD_WR), .DIN(DIN), .DOUT(DOUT)
  );

  always #5 SYSCLK = ~SYSCLK;

  // bank model: registered read data one cycle after a read select, filler otherwise
  always @(posedge SYSCLK) DOUT <= (PORT_CS && RD_WR) ? bank_rd : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge SYSCLK);
  endtask

  // advance n cycles, logging ack order and bank selects; requesters drop REQ on their ACK unless held
  task automatic run(input int n, input bit hold1, input bit hold2);
    for (int i = 0; i < n; i++) begin
      tick();
      cs_cnt += int'(PORT_CS);
      if (ACK1) begin order.push_back(1); if (!hold1) REQ1 = 0; end
      if (ACK2) begin order.push_back(2); if (!hold2) REQ2 = 0; end
    end
  endtask

  function automatic int at(input int i);
    return (order.size() > i) ? order[i] : 0;
  endfunction

  initial begin
    tick(); tick();
    chk("rst_outs", {ACK1, ACK2, ERR1, ERR2, PORT_CS, RD_WR, OFFSET_SEL}, 0);
    chk("rst_data", {RDATA1, RDATA2, DIN}, 0);
    RESET_N = 1;
    tick();
    // T1: requester 1 write to offset 3
    REQ1 = 1; RD_WR1 = 0; ADDR1 = 3; WDATA1 = 8'hA5;
    chk("t1_idle_cs", PORT_CS, 0);
    tick();
    chk("t1_cs", PORT_CS, 1);
    chk("t1_off", OFFSET_SEL, 16'h0008);
    chk("t1_din", DIN, 8'hA5);
    chk("t1_rdwr", RD_WR, 0);
    chk("t1_noack", ACK1, 0);
    tick();
    chk("t1_ack", {ACK1, ACK2, ERR1, PORT_CS}, 4'b1000);
    chk("t1_off0", OFFSET_SEL, 0);
    chk("t1_rdata", RDATA1, 0);
    REQ1 = 0;
    tick();
    chk("t1_ackend", {ACK1, PORT_CS}, 0);
    // T2: requester 2 read from offset 15
    bank_rd = 8'h3C; REQ2 = 1; RD_WR2 = 1; ADDR2 = 15;
    tick();
    chk("t2_cs", PORT_CS, 1);
    chk("t2_off", OFFSET_SEL, 16'h8000);
    chk("t2_rdwr", RD_WR, 1);
    tick();
    chk("t2_cap", {PORT_CS, ACK2}, 0);
    tick();
    chk("t2_ack", {ACK2, ACK1, ERR2, PORT_CS}, 4'b1000);
    chk("t2_rdata2", RDATA2, 8'h3C);
    chk("t2_rdata1", RDATA1, 0);
    REQ2 = 0;
    tick();
    chk("t2_hold", {ACK2, RDATA2}, {1'b0, 8'h3C});
    // T5: reset during CAPTURE of a requester 1 read
    bank_rd = 8'h77; REQ1 = 1; RD_WR1 = 1; ADDR1 = 5;
    tick(); tick();
    RESET_N = 0; REQ1 = 0;
    #1;
    chk("t5_outs", {ACK1, ACK2, ERR1, ERR2, PORT_CS, RD_WR, OFFSET_SEL}, 0);
    chk("t5_data", {RDATA1, RDATA2, DIN}, 0);
    tick(); tick();
    RESET_N = 1;
    cs_cnt = 0; order.delete();
    run(5, 0, 0);
    chk("t5_quiet", {cs_cnt[7:0], 8'(order.size())}, 0);
    chk("t5_rdata1", RDATA1, 0);
    // T3: both requesters in the same cycle out of reset, then after a lone requester-1 access
    REQ1 = 1; RD_WR1 = 0; ADDR1 = 1; WDATA1 = 8'h11;
    REQ2 = 1; RD_WR2 = 0; ADDR2 = 2; WDATA2 = 8'h22;
    cs_cnt = 0; order.delete();
    run(7, 0, 0);
    chk("t3_n", order.size(), 2);
    chk("t3_o0", at(0), 1);
    chk("t3_o1", at(1), 2);
    chk("t3_cs", cs_cnt, 2);
    REQ1 = 1; order.delete();
    run(4, 0, 0);
    chk("t3_solo", at(0), 1);
    REQ1 = 1; REQ2 = 1; order.delete();
    run(7, 0, 0);
    chk("t3_r2_n", order.size(), 2);
    chk("t3_r2_o0", at(0), 2);
    chk("t3_r2_o1", at(1), 1);
    // T4: both held continuously; service alternates with no starvation
    REQ1 = 1; REQ2 = 1; cs_cnt = 0; order.delete();
    run(11, 1, 1);
    REQ1 = 0; REQ2 = 0;
    chk("t4_n", order.size(), 4);
    chk("t4_o0", at(0), 2);
    chk("t4_o1", at(1), 1);
    chk("t4_o2", at(2), 2);
    chk("t4_o3", at(3), 1);
    chk("t4_cs", cs_cnt, 4);
    tick(); tick();
    // T6: requester 2 write to offset 0 (protected only when write protect is built in)
    REQ2 = 1; RD_WR2 = 0; ADDR2 = 0; WDATA2 = 8'h5A;
    tick();
    chk("t6_cs2", PORT_CS, !WP);
    chk("t6_off2", OFFSET_SEL, WP ? 16'h0000 : 16'h0001);
    tick();
    chk("t6_ack2", {ACK2, ERR2, PORT_CS}, {1'b1, WP, 1'b0});
    REQ2 = 0;
    tick();
    chk("t6_end2", {ACK2, ERR2}, 0);
    REQ1 = 1; RD_WR1 = 0; ADDR1 = 0; WDATA1 = 8'hC3;
    tick();
    chk("t6_cs1", {PORT_CS, OFFSET_SEL, DIN}, {1'b1, 16'h0001, 8'hC3});
    tick();
    chk("t6_ack1", {ACK1, ERR1, ACK2, ERR2}, 4'b1000);
    REQ1 = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
